// File: rtl/clkdiv_pkg.sv
// Shared types and constants for the runtime-programmable clock divider.
// The CLKDIV_DUTY50_EN build option is handled in clock_divider_n and clkdiv_dutyext.
package clkdiv_pkg;

    localparam int DIV_W_DFLT = 8;
    localparam int DIV_MIN    = 2;

    typedef logic [DIV_W_DFLT-1:0] div_t;

    function automatic div_t half_floor(input div_t n);
        return n >> 1;
    endfunction

endpackage

// File: rtl/clkdiv_dutyext.sv
// Odd-divisor duty extender: a negedge copy of q_pos stretches the high phase by half a clk.
// Only compiled when CLKDIV_DUTY50_EN is defined.
`ifdef CLKDIV_DUTY50_EN
module clkdiv_dutyext (
    input  logic clk,
    input  logic rst,
    input  logic q_pos,
    input  logic odd,
    output logic clkD
);

    logic q_neg;

    always_ff @(negedge clk) begin
        if (rst) begin
            q_neg <= 1'b0;
        end else begin
            q_neg <= q_pos;
        end
    end

    // odd is registered alongside q_pos, so the OR term cannot glitch on a divisor swap
    assign clkD = q_pos | (odd & q_neg);

endmodule
`endif

// File: rtl/clock_divider_n.sv
// Integer clock divider with divisor handshake, boundary-aligned divisor swap and period tick.
// Define CLKDIV_DUTY50_EN for exact 50% duty on odd divisors (adds one negedge flop).
module clock_divider_n
    import clkdiv_pkg::*;
#(
    parameter int DIV_W       = DIV_W_DFLT,
    parameter int DEFAULT_DIV = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] div_i,
    input  logic             div_vld,
    output logic             div_rdy,
    output logic             div_err,
    output logic             clkD,
    output logic             tick,
    output logic [DIV_W-1:0] div_cur
);

    localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
    localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'(DIV_MIN);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] cnt_next;
    logic [DIV_W-1:0] div_next;
    logic [DIV_W-1:0] pend;
    logic             pend_vld;
    logic             wrap;
    logic             xfer;
    logic             q_pos;

    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] n);
        return (n < MIN_DIV) ? MIN_DIV : n;
    endfunction

    function automatic logic [DIV_W-1:0] half_n(input logic [DIV_W-1:0] n);
        return n >> 1;
    endfunction

    always_comb begin
        wrap     = (cnt == div_cur - ONE);
        xfer     = div_vld & div_rdy;
        cnt_next = wrap ? '0 : cnt + ONE;
        // a pending divisor only lands on a wrap, so every period is whole
        div_next = (wrap && pend_vld) ? pend : div_cur;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cur  <= DEF_DIV;
            cnt      <= DEF_DIV - ONE;
            q_pos    <= 1'b0;
            tick     <= 1'b0;
            div_rdy  <= 1'b1;
            div_err  <= 1'b0;
            pend_vld <= 1'b0;
        end else begin
            cnt     <= cnt_next;
            div_cur <= div_next;
            q_pos   <= (cnt_next < half_n(div_next));
            tick    <= (cnt_next == '0);
            div_err <= xfer && (div_i < MIN_DIV);
            // xfer needs div_rdy, which implies nothing is pending, so the branches are exclusive
            if (xfer) begin
                pend_vld <= 1'b1;
                div_rdy  <= 1'b0;
            end else if (wrap && pend_vld) begin
                pend_vld <= 1'b0;
                div_rdy  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (xfer) begin
            pend <= clamp_div(div_i);
        end
    end

`ifdef CLKDIV_DUTY50_EN
    logic odd_p;

    always_ff @(posedge clk) begin
        if (rst) begin
            odd_p <= 1'b0;
        end else begin
            odd_p <= div_next[0];
        end
    end

    clkdiv_dutyext u_dutyext (
        .clk   (clk),
        .rst   (rst),
        .q_pos (q_pos),
        .odd   (odd_p),
        .clkD  (clkD)
    );
`else
    assign clkD = q_pos;
`endif

endmodule

// File: tb/tb_clock_divider_n.sv
// Directed bench for clock_divider_n: period, duty, tick, handshake and reset behaviour.
// Duty expectations follow CLKDIV_DUTY50_EN when it is defined for the build.
module tb_clock_divider_n;

    localparam int DIV_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [DIV_W-1:0] div_i;
    logic             div_vld;
    logic             div_rdy;
    logic             div_err;
    logic             clkD;
    logic             tick;
    logic [DIV_W-1:0] div_cur;

    int checks = 0;
    int errors = 0;

    logic             p_clk, n_clk, p_tick, p_rdy, p_err;
    logic [DIV_W-1:0] p_cur;
    int               rdy_cnt;

    clock_divider_n #(.DIV_W(DIV_W), .DEFAULT_DIV(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .div_i   (div_i),
        .div_vld (div_vld),
        .div_rdy (div_rdy),
        .div_err (div_err),
        .clkD    (clkD),
        .tick    (tick),
        .div_cur (div_cur)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
        end
    endtask

    // Half-clk periods of clkD high per period of divisor n
    function automatic int exp_hi(input int n);
`ifdef CLKDIV_DUTY50_EN
        return n;
`else
        return (n / 2) * 2;
`endif
    endfunction

    // One clk cycle: sample outputs after the posedge, then clkD again after the negedge
    task automatic cyc();
        @(posedge clk);
        #1;
        p_clk  = clkD;
        p_tick = tick;
        p_rdy  = div_rdy;
        p_err  = div_err;
        p_cur  = div_cur;
        @(negedge clk);
        #1;
        n_clk = clkD;
    endtask

    task automatic wait_tick(input string tag);
        int n;
        n = 0;
        do begin
            cyc();
            n++;
        end while (!p_tick && n < 600);
        if (!p_tick) chk(tag, 0, 1);
    endtask

    // Starts on the first cycle of a period; returns on the first cycle of the next one
    task automatic measure(input string tag, input int n_exp, input int hi_exp, output int rdys);
        int per;
        int hi;
        per  = 1;
        hi   = int'(p_clk) + int'(n_clk);
        rdys = int'(p_rdy);
        forever begin
            cyc();
            if (p_tick || per > 400) break;
            per++;
            hi   += int'(p_clk) + int'(n_clk);
            rdys += int'(p_rdy);
        end
        chk({tag, "_period"}, per, n_exp);
        chk({tag, "_high"}, hi, hi_exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst     = 1'b1;
        div_vld = 1'b0;
        div_i   = '0;

        // 1: reset state, then default divide-by-3
        cyc();
        cyc();
        chk("rst_clkD", int'(p_clk), 0);
        chk("rst_clkD_neg", int'(n_clk), 0);
        chk("rst_tick", int'(p_tick), 0);
        chk("rst_rdy", int'(p_rdy), 1);
        chk("rst_err", int'(p_err), 0);
        chk("rst_cur", int'(p_cur), 3);
        rst = 1'b0;
        cyc();
        chk("rel_tick", int'(p_tick), 1);
        chk("rel_clkD", int'(p_clk), 1);
        measure("n3a", 3, exp_hi(3), rdy_cnt);
        measure("n3b", 3, exp_hi(3), rdy_cnt);

        // 2: divisor 4 accepted mid-period
        div_i   = 8'd4;
        div_vld = 1'b1;
        cyc();
        chk("t2_rdy_low", int'(p_rdy), 0);
        chk("t2_cur_old", int'(p_cur), 3);
        div_vld = 1'b0;
        cyc();
        chk("t2_mid_tick", int'(p_tick), 0);
        chk("t2_mid_rdy", int'(p_rdy), 0);
        cyc();
        chk("t2_wrap_tick", int'(p_tick), 1);
        chk("t2_cur_new", int'(p_cur), 4);
        chk("t2_rdy_back", int'(p_rdy), 1);
        measure("n4", 4, exp_hi(4), rdy_cnt);

        // 3: divisors 1 and 0 clamp to 2
        div_i   = 8'd1;
        div_vld = 1'b1;
        cyc();
        chk("t3a_err", int'(p_err), 1);
        chk("t3a_rdy", int'(p_rdy), 0);
        div_vld = 1'b0;
        wait_tick("t3a_timeout");
        chk("t3a_err_clr", int'(p_err), 0);
        chk("t3a_cur", int'(p_cur), 2);
        measure("n2a", 2, exp_hi(2), rdy_cnt);
        div_i   = 8'd0;
        div_vld = 1'b1;
        cyc();
        chk("t3b_err", int'(p_err), 1);
        div_vld = 1'b0;
        wait_tick("t3b_timeout");
        chk("t3b_err_clr", int'(p_err), 0);
        chk("t3b_cur", int'(p_cur), 2);
        measure("n2b", 2, exp_hi(2), rdy_cnt);

        // 4: transfer on the wrap cycle takes effect one period later
        cyc();
        div_i   = 8'd5;
        div_vld = 1'b1;
        cyc();
        chk("t4_wrap_tick", int'(p_tick), 1);
        chk("t4_cur_kept", int'(p_cur), 2);
        chk("t4_rdy_low", int'(p_rdy), 0);
        div_vld = 1'b0;
        measure("t4_old", 2, exp_hi(2), rdy_cnt);
        chk("t4_cur_new", int'(p_cur), 5);
        chk("t4_rdy_back", int'(p_rdy), 1);
        measure("n5", 5, exp_hi(5), rdy_cnt);

        // 5: reset with a pending divisor discards it
        div_i   = 8'd8;
        div_vld = 1'b1;
        cyc();
        div_vld = 1'b0;
        wait_tick("t5_timeout");
        chk("t5_cur8", int'(p_cur), 8);
        div_i   = 8'd6;
        div_vld = 1'b1;
        cyc();
        div_vld = 1'b0;
        rst     = 1'b1;
        cyc();
        chk("t5_rst_clkD", int'(p_clk), 0);
        chk("t5_rst_cur", int'(p_cur), 3);
        chk("t5_rst_rdy", int'(p_rdy), 1);
        cyc();
        chk("t5_rst_clkD2", int'(p_clk) + int'(n_clk), 0);
        rst = 1'b0;
        cyc();
        chk("t5_rel_tick", int'(p_tick), 1);
        chk("t5_rel_cur", int'(p_cur), 3);
        measure("t5_n3", 3, exp_hi(3), rdy_cnt);
        chk("t5_no_pending", int'(p_cur), 3);

        // 6: back-to-back 2 -> 255 -> 2 with div_vld held high
        div_i   = 8'd2;
        div_vld = 1'b1;
        cyc();
        div_i = 8'd255;
        wait_tick("t6_timeout");
        chk("t6_cur2", int'(p_cur), 2);
        measure("t6_n2", 2, exp_hi(2), rdy_cnt);
        chk("t6_n2_rdy", rdy_cnt, 1);
        chk("t6_cur255", int'(p_cur), 255);
        div_i = 8'd2;
        measure("t6_n255", 255, exp_hi(255), rdy_cnt);
        chk("t6_n255_rdy", rdy_cnt, 1);
        chk("t6_cur2b", int'(p_cur), 2);
        div_vld = 1'b0;
        measure("t6_n2b", 2, exp_hi(2), rdy_cnt);
        chk("t6_n2b_rdy", rdy_cnt, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
